// File: rtl/rtc_bus_pkg.sv
// Shared state encoding and default timing for the RTC multiplexed-bus sequencer.
package rtc_bus_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_A_SETUP = 4'd1;
  localparam state_t S_A_PULSE = 4'd2;
  localparam state_t S_A_HOLD  = 4'd3;
  localparam state_t S_GAP     = 4'd4;
  localparam state_t S_D_SETUP = 4'd5;
  localparam state_t S_D_PULSE = 4'd6;
  localparam state_t S_D_HOLD  = 4'd7;
  localparam state_t S_DONE    = 4'd8;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 4;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_GAP_DEF   = 4;

  // A phase of N cycles ends when the down-counter, loaded with N-1, reaches zero.
  function automatic logic [3:0] phase_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/rtc_irq_sync.sv
// RTC interrupt path: two-flop synchronizer, falling-edge detect and sticky pending flag.
module rtc_irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic irq_ack,
  output logic irq_pending
);

  logic irq_s1, irq_s2, irq_s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_s1      <= 1'b1;
      irq_s2      <= 1'b1;
      irq_s3      <= 1'b1;
      irq_pending <= 1'b0;
    end else begin
      irq_s1 <= irq;
      irq_s2 <= irq_s1;
      irq_s3 <= irq_s2;
      // a new edge takes priority over a simultaneous acknowledge
      if (irq_s3 && !irq_s2)
        irq_pending <= 1'b1;
      else if (irq_ack)
        irq_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Address/data phase sequencer for the RTC chip's multiplexed CS/AD/RD/WR bus.
// Optional interrupt capture is built when RTC_IRQ_EN is defined.
//
// state     | meaning
// IDLE      | waiting for req_wr / req_rd
// A_SETUP   | address driven, CS/AD low, before WR strobe
// A_PULSE   | WR low, address latched by the chip
// A_HOLD    | address held after WR rises
// GAP       | CS high between address and data phases
// D_SETUP   | data phase, before the strobe
// D_PULSE   | WR (write) or RD (read) low
// D_HOLD    | data phase after the strobe
// DONE      | one-cycle completion
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       CS,
  output logic       AD,
  output logic       RD,
  output logic       WR,
  input  logic       irq,
  output logic       irq_pending,
  input  logic       irq_ack
);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       op_wr;
  logic [7:0] addr_q, wdata_q;
  logic       addr_phase, data_phase, cnt_zero, req_any;

  assign req_any    = req_wr | req_rd;
  assign cnt_zero   = (cnt == 4'd0);
  assign addr_phase = (state == S_A_SETUP) || (state == S_A_PULSE) || (state == S_A_HOLD);
  assign data_phase = (state == S_D_SETUP) || (state == S_D_PULSE) || (state == S_D_HOLD);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_zero ? cnt : cnt - 4'd1;
    case (state)
      S_IDLE:    if (req_any) begin state_nxt = S_A_SETUP; cnt_nxt = phase_load(T_SETUP); end
      S_A_SETUP: if (cnt_zero) begin state_nxt = S_A_PULSE; cnt_nxt = phase_load(T_PULSE); end
      S_A_PULSE: if (cnt_zero) begin state_nxt = S_A_HOLD;  cnt_nxt = phase_load(T_HOLD);  end
      S_A_HOLD:  if (cnt_zero) begin state_nxt = S_GAP;     cnt_nxt = phase_load(T_GAP);   end
      S_GAP:     if (cnt_zero) begin state_nxt = S_D_SETUP; cnt_nxt = phase_load(T_SETUP); end
      S_D_SETUP: if (cnt_zero) begin state_nxt = S_D_PULSE; cnt_nxt = phase_load(T_PULSE); end
      S_D_PULSE: if (cnt_zero) begin state_nxt = S_D_HOLD;  cnt_nxt = phase_load(T_HOLD);  end
      S_D_HOLD:  if (cnt_zero) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      op_wr   <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata   <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && req_any) begin
        op_wr   <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == S_D_PULSE && cnt_zero && !op_wr)
        rdata <= bus_in;
    end
  end

  // Pins are registered from the current state, so they lag the FSM by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CS      <= 1'b1;
      AD      <= 1'b1;
      RD      <= 1'b1;
      WR      <= 1'b1;
      bus_oe  <= 1'b0;
      bus_out <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      CS     <= ~(addr_phase | data_phase);
      AD     <= ~addr_phase;
      WR     <= ~((state == S_A_PULSE) || (state == S_D_PULSE && op_wr));
      RD     <= ~(state == S_D_PULSE && !op_wr);
      bus_oe <= addr_phase | (data_phase & op_wr);
      if (addr_phase)
        bus_out <= addr_q;
      else if (data_phase && op_wr)
        bus_out <= wdata_q;
      busy <= (state != S_IDLE);
      done <= (state == S_DONE);
    end
  end

`ifdef RTC_IRQ_EN
  rtc_irq_sync u_irq_sync (
    .clk         (clk),
    .reset       (reset),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .irq_pending (irq_pending)
  );
`else
  logic unused_irq;
  assign unused_irq  = irq ^ irq_ack;
  assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with default timing (21 busy cycles per transaction).
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_wr = 1'b0, req_rd = 1'b0;
  logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
  logic [7:0] rdata, bus_in = 8'hEE, bus_out;
  logic       busy, done, bus_oe, CS, AD, RD, WR;
  logic       irq = 1'b1, irq_ack = 1'b0, irq_pending;

  int checks = 0;
  int errors = 0;

  int busy_cnt, done_cnt, done_k, first_wr_k;
  int wr_addr_lo, wr_data_lo, rd_lo, gap_cnt, addr_bad, data_bad;
  logic [7:0] rdata_at_done;

  always #5 clk = ~clk;

  rtc_bus_sequencer dut (
    .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata),
    .busy(busy), .done(done), .bus_in(bus_in), .bus_out(bus_out),
    .bus_oe(bus_oe), .CS(CS), .AD(AD), .RD(RD), .WR(WR),
    .irq(irq), .irq_pending(irq_pending), .irq_ack(irq_ack)
  );

  // Issues one request, then observes 40 cycles; optionally injects a read of 0x99 at cycle extra_k.
  task automatic run_txn(input logic wr, input logic rd, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdval,
                         input int extra_k, input logic exp_wr);
    busy_cnt = 0; done_cnt = 0; done_k = -1; first_wr_k = -1;
    wr_addr_lo = 0; wr_data_lo = 0; rd_lo = 0; gap_cnt = 0; addr_bad = 0; data_bad = 0;
    rdata_at_done = 8'hxx;
    req_wr = wr; req_rd = rd; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_wr = 1'b0; req_rd = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) begin done_k = k; rdata_at_done = rdata; end
      end
      if (CS === 1'b0 && AD === 1'b0) begin
        if (WR === 1'b0) begin
          wr_addr_lo++;
          if (first_wr_k < 0) first_wr_k = k;
        end
        if (bus_oe !== 1'b1 || bus_out !== addr) addr_bad++;
      end
      if (CS === 1'b0 && AD === 1'b1) begin
        if (WR === 1'b0) wr_data_lo++;
        if (exp_wr ? (bus_oe !== 1'b1 || bus_out !== wdata) : (bus_oe !== 1'b0)) data_bad++;
      end
      if (RD === 1'b0) rd_lo++;
      if (CS === 1'b1 && busy === 1'b1 && done === 1'b0) gap_cnt++;
      bus_in = (RD === 1'b0) ? rdval : 8'hEE;
      if (k == extra_k) begin req_rd = 1'b1; req_addr = 8'h99; end
      else begin req_rd = 1'b0; req_addr = 8'h00; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({CS, AD, RD, WR, bus_oe, busy, done, irq_pending} !== 8'b1111_0000) begin
      errors++;
      $display("FAIL reset_pins: got %b expected 11110000", {CS, AD, RD, WR, bus_oe, busy, done, irq_pending});
    end
    checks++;
    if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus_out: got %h expected 00", bus_out); end
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    run_txn(1'b1, 1'b0, 8'h21, 8'h5A, 8'h00, -1, 1'b1);
    checks++; if (busy_cnt != 21) begin errors++; $display("FAIL wr_busy_cycles: got %0d expected 21", busy_cnt); end
    checks++; if (done_k != 21) begin errors++; $display("FAIL wr_done_cycle: got %0d expected 21", done_k); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wr_done_count: got %0d expected 1", done_cnt); end
    checks++; if (wr_addr_lo != 4) begin errors++; $display("FAIL wr_addr_strobe: got %0d expected 4", wr_addr_lo); end
    checks++; if (first_wr_k != 3) begin errors++; $display("FAIL wr_addr_setup: got %0d expected 3", first_wr_k); end
    checks++; if (gap_cnt != 4) begin errors++; $display("FAIL wr_gap: got %0d expected 4", gap_cnt); end
    checks++; if (wr_data_lo != 4) begin errors++; $display("FAIL wr_data_strobe: got %0d expected 4", wr_data_lo); end
    checks++; if (rd_lo != 0) begin errors++; $display("FAIL wr_rd_low: got %0d expected 0", rd_lo); end
    checks++; if (addr_bad != 0) begin errors++; $display("FAIL wr_addr_bus: got %0d bad cycles expected 0", addr_bad); end
    checks++; if (data_bad != 0) begin errors++; $display("FAIL wr_data_bus: got %0d bad cycles expected 0", data_bad); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_unchanged: got %h expected 00", rdata); end
  endtask

  task automatic test_read();
    run_txn(1'b0, 1'b1, 8'h22, 8'h00, 8'hC3, -1, 1'b0);
    checks++; if (rd_lo != 4) begin errors++; $display("FAIL rd_strobe: got %0d expected 4", rd_lo); end
    checks++; if (wr_addr_lo != 4) begin errors++; $display("FAIL rd_addr_strobe: got %0d expected 4", wr_addr_lo); end
    checks++; if (wr_data_lo != 0) begin errors++; $display("FAIL rd_data_wr: got %0d expected 0", wr_data_lo); end
    checks++; if (addr_bad != 0) begin errors++; $display("FAIL rd_addr_bus: got %0d bad cycles expected 0", addr_bad); end
    checks++; if (data_bad != 0) begin errors++; $display("FAIL rd_data_oe: got %0d bad cycles expected 0", data_bad); end
    checks++; if (rdata_at_done !== 8'hC3) begin errors++; $display("FAIL rd_rdata_done: got %h expected c3", rdata_at_done); end
    checks++; if (busy_cnt != 21) begin errors++; $display("FAIL rd_busy_cycles: got %0d expected 21", busy_cnt); end
  endtask

  task automatic test_write_after_read();
    run_txn(1'b1, 1'b0, 8'h10, 8'h99, 8'h00, -1, 1'b1);
    checks++; if (rdata !== 8'hC3) begin errors++; $display("FAIL war_rdata_hold: got %h expected c3", rdata); end
    checks++; if (data_bad != 0) begin errors++; $display("FAIL war_data_bus: got %0d bad cycles expected 0", data_bad); end
  endtask

  task automatic test_both_req();
    run_txn(1'b1, 1'b1, 8'h30, 8'hA5, 8'h11, -1, 1'b1);
    checks++; if (rd_lo != 0) begin errors++; $display("FAIL both_rd_low: got %0d expected 0", rd_lo); end
    checks++; if (wr_data_lo != 4) begin errors++; $display("FAIL both_wr_strobe: got %0d expected 4", wr_data_lo); end
    checks++; if (data_bad != 0) begin errors++; $display("FAIL both_data_bus: got %0d bad cycles expected 0", data_bad); end
    checks++; if (rdata !== 8'hC3) begin errors++; $display("FAIL both_rdata: got %h expected c3", rdata); end
  endtask

  task automatic test_busy_ignore();
    run_txn(1'b1, 1'b0, 8'h40, 8'h77, 8'h00, 5, 1'b1);
    checks++; if (busy_cnt != 21) begin errors++; $display("FAIL ign_busy_cycles: got %0d expected 21", busy_cnt); end
    checks++; if (done_k != 21) begin errors++; $display("FAIL ign_done_cycle: got %0d expected 21", done_k); end
    checks++; if (addr_bad != 0) begin errors++; $display("FAIL ign_addr_bus: got %0d bad cycles expected 0", addr_bad); end
    checks++; if (rd_lo != 0) begin errors++; $display("FAIL ign_rd_low: got %0d expected 0", rd_lo); end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 1'b0, 8'h50, 8'h12, 8'h3C, 21, 1'b1);
    checks++; if (busy_cnt != 39) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 39", busy_cnt); end
    checks++; if (rd_lo != 4) begin errors++; $display("FAIL b2b_rd_low: got %0d expected 4", rd_lo); end
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL b2b_rdata: got %h expected 3c", rdata); end
  endtask

  task automatic test_irq();
    int lat;
`ifdef RTC_IRQ_EN
    lat = 0;
    irq = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (irq_pending === 1'b1 && lat == 0) lat = k;
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL irq_latency: got %0d expected 3", lat); end
    irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_ack_clear: got %b expected 0", irq_pending); end
    irq = 1'b1; repeat (4) @(negedge clk);
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_rise: got %b expected 0", irq_pending); end
    irq = 1'b0;
    repeat (2) @(negedge clk);
    irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
    checks++; if (irq_pending !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b expected 1", irq_pending); end
    irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0; irq = 1'b1;
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_ack_clear2: got %b expected 0", irq_pending); end
`else
    lat = 0;
    irq = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (irq_pending !== 1'b0) lat++;
    end
    irq = 1'b1;
    checks++; if (lat != 0) begin errors++; $display("FAIL irq_disabled: got %0d pending cycles expected 0", lat); end
`endif
  endtask

  task automatic test_reset_mid();
    int dn, bz;
    req_rd = 1'b1; req_addr = 8'h22;
    @(negedge clk);
    req_rd = 1'b0; req_addr = 8'h00;
    repeat (16) @(negedge clk);
    checks++; if (RD !== 1'b0) begin errors++; $display("FAIL rst_mid_in_pulse: got RD=%b expected 0", RD); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({CS, AD, RD, WR, bus_oe, busy, done} !== 7'b1111_000) begin
      errors++;
      $display("FAIL rst_mid_pins: got %b expected 1111000", {CS, AD, RD, WR, bus_oe, busy, done});
    end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 00", rdata); end
    @(negedge clk);
    reset = 1'b1;
    dn = 0; bz = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
      if (busy !== 1'b0) bz++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d done cycles expected 0", dn); end
    checks++; if (bz != 0) begin errors++; $display("FAIL rst_mid_busy: got %0d busy cycles expected 0", bz); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_write_after_read();
    test_both_req();
    test_busy_ignore();
    test_back_to_back();
    test_irq();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Sequencer for the real-time-clock chip's multiplexed 8-bit bus (CS/AD/RD/WR, active-low strobes). It sits between the microcontroller's RTC port decode and the chip pins. It turns a single-cycle read or write request into a timed address phase followed by a data phase, and returns read data with a done pulse.

## Interface
Parameters:
- T_SETUP, 2: cycles spent in each setup state, before a strobe (1..15).
- T_PULSE, 4: cycles RD or WR is held low (1..15).
- T_HOLD, 2: cycles spent in each hold state, after a strobe (1..15).
- T_GAP, 4: cycles with CS high between the address phase and the data phase (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_wr  in  1  single-cycle write request.
- req_rd  in  1  single-cycle read request.
- req_addr  in  8  RTC register address.
- req_wdata  in  8  write data.
- rdata  out  8  last read result.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- bus_in  in  8  pad input data.
- bus_out  out  8  pad output data.
- bus_oe  out  1  pad output enable.
- CS, AD, RD, WR  out  1 each  chip pins. CS/RD/WR are active-low. AD=0 marks the address phase.
- irq  in  1  RTC interrupt, active-low, asynchronous.
- irq_pending  out  1  latched interrupt flag.
- irq_ack  in  1  clears irq_pending.

## Operation
- States: IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, DONE.
- Phase length: each timed state lasts its parameter's cycles, counted by a down-counter loaded on entry. The counter is 4 bits wide.
- IDLE: a request on req_wr or req_rd latches the op, req_addr and req_wdata, then moves to A_SETUP.
  - Simultaneous req_wr and req_rd: the write wins and the read is dropped.
  - Requests outside IDLE are ignored; there is no queueing.
- Address phase (A_SETUP, A_PULSE, A_HOLD): CS=0, AD=0, bus_oe=1, bus_out=address. WR=0 only in A_PULSE.
- GAP: CS=1, AD=1, bus_oe=0.
- Data phase (D_SETUP, D_PULSE, D_HOLD): CS=0, AD=1.
  - Write: bus_oe=1, bus_out=wdata, WR=0 in D_PULSE.
  - Read: bus_oe=0, RD=0 in D_PULSE. rdata captures bus_in on the clock edge that ends D_PULSE.
- DONE: lasts 1 cycle. done=1, then the FSM returns to IDLE.
- busy=1 in every state except IDLE.
- rdata holds its value until the next read completes. Writes do not change rdata.
- Outside the phases listed above: CS, AD, RD and WR are 1, and bus_oe is 0.
- Reset values, applied asynchronously and immediately even mid-transaction:
  - CS, AD, RD, WR = 1.
  - bus_oe=0, bus_out=0x00, rdata=0x00.
  - busy=0, done=0, irq_pending=0.
  - State = IDLE.

## Timing
- Request sampled at edge 0. busy rises at edge 1.
- Total busy cycles = 2·T_SETUP + 2·T_PULSE + 2·T_HOLD + T_GAP + 1. With default parameters this is 21.
- done is high in the cycle after D_HOLD ends. A new request is accepted on the first cycle back in IDLE.
- Strobes are glitch-free: CS, AD, RD, WR, bus_oe and bus_out are all registered outputs.
- bus_out is stable for at least T_SETUP cycles before WR falls and T_HOLD cycles after it rises.

## Configuration
- RTC_IRQ_EN defined:
  - irq passes through a two-flop synchronizer.
  - A falling edge of the synchronized irq sets irq_pending.
  - irq_ack clears irq_pending.
  - If an edge and irq_ack arrive in the same cycle, set wins.
- RTC_IRQ_EN undefined: irq is unused, irq_pending is tied to 0, and irq_ack is ignored.

## Structure
- Package rtc_bus_pkg holds the state enum and the default timing constants.
- Sub-module rtc_irq_sync holds the synchronizer, edge detector and pending flag. It is instantiated only under RTC_IRQ_EN.

## Test plan
- Write 0x5A to address 0x21 with default parameters:
  - Address phase: AD=0, bus_out=0x21, WR low for 4 cycles.
  - GAP: CS high for 4 cycles.
  - Data phase: bus_out=0x5A, WR low for 4 cycles.
  - done appears on cycle 21 after the request.
- Read from address 0x22 with bus_in=0xC3 during D_PULSE:
  - RD is low for 4 cycles and bus_oe=0 during the data phase.
  - rdata=0xC3 when done pulses.
  - rdata stays 0xC3 after a following write.
- req_wr and req_rd in the same cycle: a write cycle is generated and RD never falls.
- Request asserted while busy: it is ignored and the current transaction timing is unchanged.
- Reset asserted during D_PULSE:
  - All pins return to idle values in the same cycle, without waiting for a clock.
  - busy=0, and no done pulse follows.
- With RTC_IRQ_EN defined:
  - irq falling sets irq_pending 2–3 cycles later, and irq_ack clears it.
  - An edge coinciding with irq_ack leaves irq_pending=1.
